// File: rtl/uart_apb_regif.sv
// APB register interface for a UART core: TX/RX data strobes, baud/format
// configuration, status readback and edge-triggered interrupt pending bits.
module uart_apb_regif #(
    parameter int FIXEDMODE         = 0,
    parameter int BAUD_VALUE        = 1,
    parameter int PRG_BIT8          = 0,
    parameter int PRG_PARITY        = 0,
    parameter int BAUD_VAL_FRCTN_EN = 0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [7:0]  PWDATA,
    output logic [7:0]  PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        CSN,
    output logic        WEN,
    output logic        OEN,
    output logic [7:0]  DATA_IN,
    input  logic [7:0]  DATA_OUT,
    input  logic        TXRDY,
    input  logic        RXRDY,
    input  logic        PARITY_ERR,
    input  logic        OVERFLOW,
    input  logic        FRAMING_ERR,
    output logic [12:0] BAUD_VAL,
    output logic        BIT8,
    output logic        PARITY_EN,
    output logic        ODD_N_EVEN,
    output logic [2:0]  BAUD_VAL_FRACTION,
    output logic        IRQ
);

    localparam logic [2:0] ADDR_TXDATA  = 3'd0;
    localparam logic [2:0] ADDR_RXDATA  = 3'd1;
    localparam logic [2:0] ADDR_CTRL1   = 3'd2;
    localparam logic [2:0] ADDR_CTRL2   = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [2:0] ADDR_CTRL3   = 3'd5;
    localparam logic [2:0] ADDR_INTEN   = 3'd6;
    localparam logic [2:0] ADDR_INTSTAT = 3'd7;

    // Fixed-mode configuration; in programmable mode the CTRL registers reset to 0.
    localparam logic [12:0] FIXED_BAUD = 13'(BAUD_VALUE);
    localparam logic [1:0]  FIXED_PAR  = 2'(PRG_PARITY);
    localparam logic        FIXED_BIT8 = 1'(PRG_BIT8);
    localparam logic [7:0]  CTRL1_INIT = (FIXEDMODE != 0) ? FIXED_BAUD[7:0] : 8'h00;
    localparam logic [7:0]  CTRL2_INIT = (FIXEDMODE != 0) ?
        {FIXED_BAUD[12:8], FIXED_PAR[0], FIXED_PAR[1], FIXED_BIT8} : 8'h00;

    logic [2:0] word;
    logic       setup, wr_access;
    logic       csn_reg, wen_reg, oen_reg;
    logic [7:0] data_in_reg;
    logic [7:0] ctrl1_reg, ctrl2_reg;
    logic [2:0] ctrl3_reg, inten_reg, intstat_reg, intstat_next;
    logic [2:0] status_d_reg, status_now, rise, w1c;
    logic       irq_reg;
    logic       unused_addr_bits;

    assign word             = PADDR[4:2];
    assign unused_addr_bits = ^PADDR[1:0];
    assign setup            = PSEL & ~PENABLE;
    assign wr_access        = PSEL & PENABLE & PWRITE;

    // Core strobes are registered from the setup-phase decode so they line up with the access cycle.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            csn_reg     <= 1'b1;
            wen_reg     <= 1'b1;
            oen_reg     <= 1'b1;
            data_in_reg <= 8'h00;
        end else begin
            csn_reg <= 1'b1;
            wen_reg <= 1'b1;
            oen_reg <= 1'b1;
            if (setup && PWRITE && word == ADDR_TXDATA) begin
                csn_reg     <= 1'b0;
                wen_reg     <= 1'b0;
                data_in_reg <= PWDATA;
            end else if (setup && !PWRITE && word == ADDR_RXDATA) begin
                csn_reg <= 1'b0;
                oen_reg <= 1'b0;
            end
        end
    end

    // Configuration and interrupt-enable registers, written on the access edge.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ctrl1_reg <= CTRL1_INIT;
            ctrl2_reg <= CTRL2_INIT;
            ctrl3_reg <= 3'b000;
            inten_reg <= 3'b000;
        end else if (wr_access) begin
            if (FIXEDMODE == 0) begin
                if (word == ADDR_CTRL1) ctrl1_reg <= PWDATA;
                if (word == ADDR_CTRL2) ctrl2_reg <= PWDATA;
                if (word == ADDR_CTRL3) ctrl3_reg <= PWDATA[2:0];
            end
            if (word == ADDR_INTEN) inten_reg <= PWDATA[2:0];
        end
    end

    // Pending bits: {err, rx, tx}; a rising edge outranks a same-cycle W1C clear.
    assign status_now = {PARITY_ERR | OVERFLOW | FRAMING_ERR, RXRDY, TXRDY};
    assign rise       = status_now & ~status_d_reg;
    assign w1c        = (wr_access && word == ADDR_INTSTAT) ? PWDATA[2:0] : 3'b000;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_pending
            assign intstat_next[gi] = rise[gi] | (intstat_reg[gi] & ~w1c[gi]);
        end
    endgenerate

    // Delayed status copies, pending register and registered IRQ; TXRDY copy resets high
    // so an idle transmitter does not raise a tx pending bit on reset release.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            status_d_reg <= 3'b001;
            intstat_reg  <= 3'b000;
            irq_reg      <= 1'b0;
        end else begin
            status_d_reg <= status_now;
            intstat_reg  <= intstat_next;
            irq_reg      <= |(intstat_reg & inten_reg);
        end
    end

    // Combinational read mux, driven only during the access phase of a read.
    always_comb begin
        PRDATA = 8'h00;
        if (PSEL && PENABLE && !PWRITE) begin
            case (word)
                ADDR_RXDATA:  PRDATA = DATA_OUT;
                ADDR_CTRL1:   PRDATA = ctrl1_reg;
                ADDR_CTRL2:   PRDATA = ctrl2_reg;
                ADDR_STATUS:  PRDATA = {3'b000, FRAMING_ERR, OVERFLOW, PARITY_ERR, RXRDY, TXRDY};
                ADDR_CTRL3:   PRDATA = {5'b00000, ctrl3_reg};
                ADDR_INTEN:   PRDATA = {5'b00000, inten_reg};
                ADDR_INTSTAT: PRDATA = {5'b00000, intstat_reg};
                default:      PRDATA = 8'h00;
            endcase
        end
    end

    assign PREADY            = 1'b1;
    assign PSLVERR           = 1'b0;
    assign CSN               = csn_reg;
    assign WEN               = wen_reg;
    assign OEN               = oen_reg;
    assign DATA_IN           = data_in_reg;
    assign BAUD_VAL          = {ctrl2_reg[7:3], ctrl1_reg};
    assign ODD_N_EVEN        = ctrl2_reg[2];
    assign PARITY_EN         = ctrl2_reg[1];
    assign BIT8              = ctrl2_reg[0];
    assign BAUD_VAL_FRACTION = (BAUD_VAL_FRCTN_EN != 0) ? ctrl3_reg : 3'b000;
    assign IRQ               = irq_reg;

endmodule

// File: tb/tb_uart_apb_regif.sv
// Self-checking bench for uart_apb_regif: directed scenarios plus randomized APB
// traffic against a transaction-level register/interrupt model.
module tb_uart_apb_regif;

    logic        clk = 1'b0;
    logic        reset_n, psel, penable, pwrite;
    logic [4:0]  paddr;
    logic [7:0]  pwdata, data_out;
    logic        txrdy, rxrdy, parity_err, overflow, framing_err;

    logic [7:0]  prdata, data_in, prdata_f, data_in_f;
    logic        pready, pslverr, csn, wen, oen, bit8, parity_en, odd_n_even, irq;
    logic        pready_f, pslverr_f, csn_f, wen_f, oen_f, bit8_f, parity_en_f, odd_n_even_f, irq_f;
    logic [12:0] baud_val, baud_val_f;
    logic [2:0]  frac, frac_f;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_ctrl1, m_ctrl2, m_data_in;
    logic [2:0] m_ctrl3, m_inten, m_intstat, m_prev;
    logic [2:0] w1c_mask = 3'b000;
    logic       m_irq;

    always #5 clk = ~clk;

    uart_apb_regif #(.FIXEDMODE(0), .BAUD_VAL_FRCTN_EN(1)) dut (
        .CLK(clk), .RESET_N(reset_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .CSN(csn), .WEN(wen), .OEN(oen), .DATA_IN(data_in), .DATA_OUT(data_out),
        .TXRDY(txrdy), .RXRDY(rxrdy), .PARITY_ERR(parity_err), .OVERFLOW(overflow),
        .FRAMING_ERR(framing_err), .BAUD_VAL(baud_val), .BIT8(bit8), .PARITY_EN(parity_en),
        .ODD_N_EVEN(odd_n_even), .BAUD_VAL_FRACTION(frac), .IRQ(irq)
    );

    uart_apb_regif #(.FIXEDMODE(1), .BAUD_VALUE(27), .PRG_BIT8(1), .PRG_PARITY(2),
                     .BAUD_VAL_FRCTN_EN(0)) dut_fixed (
        .CLK(clk), .RESET_N(reset_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_f), .PREADY(pready_f), .PSLVERR(pslverr_f),
        .CSN(csn_f), .WEN(wen_f), .OEN(oen_f), .DATA_IN(data_in_f), .DATA_OUT(data_out),
        .TXRDY(txrdy), .RXRDY(rxrdy), .PARITY_ERR(parity_err), .OVERFLOW(overflow),
        .FRAMING_ERR(framing_err), .BAUD_VAL(baud_val_f), .BIT8(bit8_f), .PARITY_EN(parity_en_f),
        .ODD_N_EVEN(odd_n_even_f), .BAUD_VAL_FRACTION(frac_f), .IRQ(irq_f)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("assertion %s", tag);
        end
    endtask

    // Advance one clock; the model consumes the inputs present at this edge.
    task automatic step();
        logic [2:0] cur, rise;
        cur = {parity_err | overflow | framing_err, rxrdy, txrdy};
        if (!reset_n) begin
            m_ctrl1 = 8'h00; m_ctrl2 = 8'h00; m_ctrl3 = 3'b000; m_data_in = 8'h00;
            m_inten = 3'b000; m_intstat = 3'b000; m_irq = 1'b0; m_prev = 3'b001;
        end else begin
            rise      = cur & ~m_prev;
            m_irq     = |(m_intstat & m_inten);
            m_intstat = (m_intstat & ~w1c_mask) | rise;
            m_prev    = cur;
        end
        @(posedge clk); #1;
        chk("irq", 16'(irq), 16'(m_irq));
    endtask

    function automatic logic [7:0] exp_read(input logic [2:0] a, input bit fixed);
        case (a)
            3'd1: return data_out;
            3'd2: return fixed ? 8'd27 : m_ctrl1;
            3'd3: return fixed ? 8'h03 : m_ctrl2;
            3'd4: return {3'b000, framing_err, overflow, parity_err, rxrdy, txrdy};
            3'd5: return fixed ? 8'h00 : {5'b0, m_ctrl3};
            3'd6: return {5'b0, m_inten};
            3'd7: return {5'b0, m_intstat};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_cfg();
        chk("baud_val", 16'(baud_val), 16'({m_ctrl2[7:3], m_ctrl1}));
        chk("bit8", 16'(bit8), 16'(m_ctrl2[0]));
        chk("parity_en", 16'(parity_en), 16'(m_ctrl2[1]));
        chk("odd_n_even", 16'(odd_n_even), 16'(m_ctrl2[2]));
        chk("fraction", 16'(frac), 16'(m_ctrl3));
        chk("fixed_baud_val", 16'(baud_val_f), 16'd27);
        chk("fixed_format", 16'({odd_n_even_f, parity_en_f, bit8_f, frac_f}), 16'b011_000);
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {a, 2'b00}; pwdata = d;
        step();
        if (a == 3'd0) m_data_in = d;
        chk("wr_csn_access", 16'(csn), 16'(a != 3'd0));
        chk("wr_wen_access", 16'(wen), 16'(a != 3'd0));
        chk("wr_oen_access", 16'(oen), 16'd1);
        penable = 1'b1;
        if (a == 3'd7) w1c_mask = d[2:0];
        step();
        w1c_mask = 3'b000;
        case (a)
            3'd2: m_ctrl1 = d;
            3'd3: m_ctrl2 = d;
            3'd5: m_ctrl3 = d[2:0];
            3'd6: m_inten = d[2:0];
            default: ;
        endcase
        psel = 1'b0; penable = 1'b0;
        chk("wr_csn_after", 16'({csn, wen}), 16'b11);
        chk("data_in", 16'(data_in), 16'(m_data_in));
        chk("fixed_data_in", 16'(data_in_f), 16'(m_data_in));
        $display("write addr=%0d data=%02h", a, d);
    endtask

    task automatic apb_read(input logic [2:0] a, output logic [7:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {a, 2'b00};
        #1 chk("rd_prdata_setup", 16'(prdata), 16'd0);
        step();
        chk("rd_csn_access", 16'(csn), 16'(a != 3'd1));
        chk("rd_oen_access", 16'(oen), 16'(a != 3'd1));
        chk("rd_wen_access", 16'(wen), 16'd1);
        penable = 1'b1;
        #1;
        d = prdata;
        chk("rd_prdata", 16'(prdata), 16'(exp_read(a, 1'b0)));
        chk("fixed_rd_prdata", 16'(prdata_f), 16'(exp_read(a, 1'b1)));
        step();
        psel = 1'b0; penable = 1'b0;
        #1 chk("rd_prdata_idle", 16'(prdata), 16'd0);
        chk("rd_strobes_after", 16'({csn, oen}), 16'b11);
        $display("read  addr=%0d data=%02h", a, d);
    endtask

    initial begin
        logic [7:0] rd;
        logic [2:0] a;
        logic [7:0] d;

        reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 5'd0;
        pwdata = 8'h00; data_out = 8'h00;
        txrdy = 1'b1; rxrdy = 1'b0; parity_err = 1'b0; overflow = 1'b0; framing_err = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("reset_strobes", 16'({csn, wen, oen}), 16'b111);
        chk("reset_data_in", 16'(data_in), 16'd0);
        chk("apb_tieoffs", 16'({pready, pslverr}), 16'b10);
        check_cfg();

        // TX write and RX read
        apb_write(3'd0, 8'hA5);
        step();
        chk("tx_data_in_held", 16'(data_in), 16'h00A5);
        data_out = 8'h3C;
        apb_read(3'd1, rd);
        chk("rx_prdata", 16'(rd), 16'h003C);

        // Configuration
        apb_write(3'd2, 8'h1B);
        apb_write(3'd3, 8'hF9);
        check_cfg();
        chk("cfg_baud_const", 16'(baud_val), 16'h1F1B);
        chk("cfg_format_const", 16'({odd_n_even, parity_en, bit8}), 16'b001);
        apb_write(3'd5, 8'hFE);
        check_cfg();

        // Aborted transfer: PSEL drops after setup, strobe still issued
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd0; pwdata = 8'h77;
        step();
        m_data_in = 8'h77;
        chk("abort_csn", 16'({csn, wen}), 16'b00);
        psel = 1'b0;
        step();
        chk("abort_after", 16'({csn, wen, data_in}), 16'({2'b11, 8'h77}));

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) txrdy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) rxrdy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) parity_err = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) overflow = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) framing_err = 1'($urandom_range(0, 1));
            data_out = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                apb_write(a, d);
                check_cfg();
            end else begin
                apb_read(a, rd);
            end
            repeat ($urandom_range(0, 2)) step();
        end

        // Interrupt scenario
        txrdy = 1'b1; rxrdy = 1'b0; parity_err = 1'b0; overflow = 1'b0; framing_err = 1'b0;
        step(); step();
        apb_write(3'd6, 8'h00);
        apb_write(3'd7, 8'h07);
        step(); step();
        apb_write(3'd6, 8'h02);
        step();
        rxrdy = 1'b1;
        step();
        chk("irq_lag_0", 16'(irq), 16'd0);
        step();
        chk("irq_set", 16'(irq), 16'd1);
        apb_read(3'd7, rd);
        chk("intstat_rx", 16'(rd), 16'h0002);
        apb_write(3'd7, 8'h02);
        step();
        chk("irq_cleared", 16'(irq), 16'd0);

        // Set/clear collision on err
        apb_write(3'd6, 8'h04);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = {3'd7, 2'b00}; pwdata = 8'h04;
        step();
        penable = 1'b1; framing_err = 1'b1; w1c_mask = 3'b100;
        step();
        w1c_mask = 3'b000; psel = 1'b0; penable = 1'b0;
        apb_read(3'd7, rd);
        chk("collision_err_kept", 16'(rd[2]), 16'd1);

        // Reset during a TXDATA access phase
        framing_err = 1'b0; rxrdy = 1'b0; txrdy = 1'b1;
        step(); step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'd0; pwdata = 8'h5A;
        step();
        m_data_in = 8'h5A;
        chk("rst_mid_csn_low", 16'(csn), 16'd0);
        penable = 1'b1; reset_n = 1'b0;
        step();
        chk("rst_mid_strobes", 16'({csn, wen, oen}), 16'b111);
        chk("rst_mid_data_in", 16'(data_in), 16'd0);
        chk("rst_mid_irq", 16'(irq), 16'd0);
        check_cfg();
        psel = 1'b0; penable = 1'b0; reset_n = 1'b1;
        step(); step();
        apb_write(3'd6, 8'h07);
        step(); step();
        chk("rst_release_irq", 16'(irq), 16'd0);
        apb_read(3'd7, rd);
        chk("rst_release_intstat", 16'(rd), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
